// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN layer sequencer.
// Holds the sequencer state enum, the layer codes driven on the layer port,
// and the memory-select encoding for the three bank groups.
package cnn_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StL0,
        StL1,
        StL2,
        StFin
    } seq_state_e;

    localparam logic [1:0] LayerConv = 2'd0;
    localparam logic [1:0] LayerPool = 2'd1;
    localparam logic [1:0] LayerFlat = 2'd2;

    typedef enum logic [1:0] {
        BankL0,   // conv output maps, one per kernel
        BankL1,   // pooled maps, one per kernel
        BankFlat  // single flattened vector
    } csel_bank_e;

    // csel 0 is reserved for "no memory selected".
    function automatic int unsigned csel_enc(input csel_bank_e  bank,
                                             input int unsigned ker,
                                             input int unsigned num_ker);
        int unsigned sel;
        case (bank)
            BankL0:   sel = 1 + ker;
            BankL1:   sel = 1 + num_ker + ker;
            BankFlat: sel = 2 * num_ker + 1;
            default:  sel = 0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/layer_seq_cnt.sv
// Kernel / tap / output-pixel counter chain for layer_seq_ctrl.
// Ports:
//   clk_i, reset_i  - clock, synchronous active-high reset
//   ker_step_i      - advance the kernel index alone (conv layer)
//   tap_en_i        - run the tap -> kernel -> pixel chain (pool/flatten)
//   ker_max_i       - last kernel index
//   tap_max_i       - last tap value of the current layer
//   pix_max_i       - last output pixel index
//   ker_o, tap_o    - current kernel index and tap phase
//   ker_last_o      - kernel index is at ker_max_i
//   pix_done_o      - final cycle of the final pixel of the layer
//   pix_adv_o       - registered pulse, high the cycle after the pixel index advanced
module layer_seq_cnt #(
    parameter int unsigned KER_W = 1,
    parameter int unsigned TAP_W = 3,
    parameter int unsigned PIX_W = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ker_step_i,
    input  logic             tap_en_i,
    input  logic [KER_W-1:0] ker_max_i,
    input  logic [TAP_W-1:0] tap_max_i,
    input  logic [PIX_W-1:0] pix_max_i,
    output logic [KER_W-1:0] ker_o,
    output logic [TAP_W-1:0] tap_o,
    output logic             ker_last_o,
    output logic             pix_done_o,
    output logic             pix_adv_o
);

    logic [KER_W-1:0] ker_q, ker_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             pix_adv_q, pix_adv_d;
    logic             tap_last, ker_last, pix_last;

    assign tap_last = (tap_q == tap_max_i);
    assign ker_last = (ker_q == ker_max_i);
    assign pix_last = (pix_q == pix_max_i);

    always_comb begin
        ker_d     = ker_q;
        tap_d     = tap_q;
        pix_d     = pix_q;
        pix_adv_d = 1'b0;
        if (tap_en_i) begin
            if (tap_last) begin
                tap_d = '0;
                if (ker_last) begin
                    ker_d     = '0;
                    pix_d     = pix_last ? '0 : pix_q + PIX_W'(1);
                    pix_adv_d = 1'b1;
                end else begin
                    ker_d = ker_q + KER_W'(1);
                end
            end else begin
                tap_d = tap_q + TAP_W'(1);
            end
        end else if (ker_step_i) begin
            ker_d = ker_last ? '0 : ker_q + KER_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ker_q     <= '0;
            tap_q     <= '0;
            pix_q     <= '0;
            pix_adv_q <= 1'b0;
        end else begin
            ker_q     <= ker_d;
            tap_q     <= tap_d;
            pix_q     <= pix_d;
            pix_adv_q <= pix_adv_d;
        end
    end

    assign ker_o      = ker_q;
    assign tap_o      = tap_q;
    assign ker_last_o = ker_last;
    assign pix_done_o = tap_en_i & tap_last & ker_last & pix_last;
    assign pix_adv_o  = pix_adv_q;

endmodule

// File: rtl/layer_seq_ctrl.sv
// CNN layer sequencer: conv (L0) -> max-pool (L1) -> optional flatten (L2).
// Ports:
//   clk_i, reset_i        - clock, synchronous active-high reset
//   ready_i               - start request, honoured only when idle
//   busy_o                - high from accepted start until the finish cycle ends
//   pix_valid_i           - conv datapath result valid (write strobe in L0)
//   map_done_i            - last conv pixel of the current kernel
//   crd_o, cwr_o, csel_o  - memory read/write strobes and bank select
//   ker_o, layer_o, tap_o - kernel index, layer code, pool/flatten phase
//   pix_adv_o             - pulse after the output pixel index advanced
module layer_seq_ctrl
    import cnn_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W   = 64,
    parameter int unsigned NUM_KER = 2,
    parameter int unsigned POOL    = 2,
    parameter int unsigned FLAT_EN = 1,
    localparam int unsigned CSEL_W = $clog2(2 * NUM_KER + 2),
    localparam int unsigned KER_W  = (NUM_KER > 1) ? $clog2(NUM_KER) : 1,
    localparam int unsigned TAP_W  = $clog2(POOL * POOL + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ready_i,
    output logic              busy_o,
    input  logic              pix_valid_i,
    input  logic              map_done_i,
    output logic              crd_o,
    output logic              cwr_o,
    output logic [CSEL_W-1:0] csel_o,
    output logic [KER_W-1:0]  ker_o,
    output logic [1:0]        layer_o,
    output logic [TAP_W-1:0]  tap_o,
    output logic              pix_adv_o
);

    localparam int unsigned PP      = POOL * POOL;
    localparam int unsigned OUT_PIX = (IMG_W / POOL) * (IMG_W / POOL);
    localparam int unsigned PIX_W   = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1;

    seq_state_e       state_q;
    logic             busy_q;
    logic             ker_step, tap_en;
    logic [TAP_W-1:0] tap_max;
    logic             ker_last, pix_done;
    logic [KER_W-1:0] ker;
    logic [TAP_W-1:0] tap;

    // Pooling reads PP taps then writes once; flatten reads once then writes.
    always_comb begin
        ker_step = 1'b0;
        tap_en   = 1'b0;
        tap_max  = TAP_W'(PP);
        case (state_q)
            StL0: ker_step = map_done_i;
            StL1: tap_en = 1'b1;
            StL2: begin
                tap_en  = 1'b1;
                tap_max = TAP_W'(1);
            end
            default: ;
        endcase
    end

    layer_seq_cnt #(
        .KER_W(KER_W),
        .TAP_W(TAP_W),
        .PIX_W(PIX_W)
    ) u_cnt (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .ker_step_i(ker_step),
        .tap_en_i  (tap_en),
        .ker_max_i (KER_W'(NUM_KER - 1)),
        .tap_max_i (tap_max),
        .pix_max_i (PIX_W'(OUT_PIX - 1)),
        .ker_o     (ker),
        .tap_o     (tap),
        .ker_last_o(ker_last),
        .pix_done_o(pix_done),
        .pix_adv_o (pix_adv_o)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ready_i) begin
                        state_q <= StL0;
                        busy_q  <= 1'b1;
                    end
                end
                StL0: if (map_done_i && ker_last) state_q <= StL1;
                StL1: if (pix_done) state_q <= (FLAT_EN != 0) ? StL2 : StFin;
                StL2: if (pix_done) state_q <= StFin;
                StFin: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Strobes decode from the current state and counters so they line up
    // with the ker/tap values visible in the same cycle.
    always_comb begin
        layer_o = LayerConv;
        crd_o   = 1'b0;
        cwr_o   = 1'b0;
        csel_o  = '0;
        case (state_q)
            StL0: begin
                cwr_o  = pix_valid_i;
                csel_o = CSEL_W'(csel_enc(BankL0, 32'(ker), NUM_KER));
            end
            StL1: begin
                layer_o = LayerPool;
                if (tap == TAP_W'(PP)) begin
                    cwr_o  = 1'b1;
                    csel_o = CSEL_W'(csel_enc(BankL1, 32'(ker), NUM_KER));
                end else begin
                    crd_o  = 1'b1;
                    csel_o = CSEL_W'(csel_enc(BankL0, 32'(ker), NUM_KER));
                end
            end
            StL2: begin
                layer_o = LayerFlat;
                if (tap == '0) begin
                    crd_o  = 1'b1;
                    csel_o = CSEL_W'(csel_enc(BankL1, 32'(ker), NUM_KER));
                end else begin
                    cwr_o  = 1'b1;
                    csel_o = CSEL_W'(csel_enc(BankFlat, 32'(ker), NUM_KER));
                end
            end
            default: ;
        endcase
    end

    assign busy_o = busy_q;
    assign ker_o  = ker;
    assign tap_o  = tap;

endmodule
